alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 64-bit ALU among N requesters through a round-robin arbiter, with a valid/ready request and response handshake per requester.
- Registers operands and the result, so the combinational ALU sits between two flop stages.
- Flags unsupported ALUControl codes without using the ALU.
- Used as the shared-execute resource when several pipeline or coprocessor clients issue arithmetic.

Parameters:
- N, 2, number of requesters (2..8).
- WIDTH, 64, operand and result width.
- CNT_W, 32, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester request accepted this cycle.
- req_a  in  N x WIDTH  operand A per requester.
- req_b  in  N x WIDTH  operand B per requester.
- req_op  in  N x 4  ALUControl code per requester.
- rsp_valid  out  N  one-hot response valid, addressed to the granted requester.
- rsp_ready  in  N  per-requester response accept.
- rsp_result  out  WIDTH  shared response data.
- rsp_zero  out  1  shared zero flag (result == 0).
- rsp_err  out  1  1 = illegal op code.
- busy  out  1  state != IDLE.
- ops_done  out  CNT_W  completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Reset values, applied asynchronously while reset == 0:
  - state = IDLE.
  - All registers, rsp_* outputs, busy and ops_done = 0.
  - Arbiter pointer = N-1, so requester 0 has top priority first.
- Reset mid-operation drops the outstanding op; no response is produced after release.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - The arbiter picks the first i with req_valid[i]=1, searching from pointer+1 with wrap-around.
  - req_ready[i]=1 combinationally for that i only; all other req_ready bits are 0.
  - On the accepting edge:
    - latch a, b, op and grant index g into registers;
    - set pointer = g;
    - go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (one cycle):
  - The registered operands drive the alu instance.
  - At the edge, capture alu result and zero into rsp_result and rsp_zero.
  - Go to RESP.
- RESP:
  - rsp_valid[g]=1; rsp_result, rsp_zero and rsp_err are held stable.
  - rsp_ready bits other than rsp_ready[g] are ignored.
  - When rsp_ready[g]=1 at an edge: ops_done++, go to IDLE.
- Latency: accept at edge T gives rsp_valid visible after edge T+1. Minimum 3 cycles per op; no overlap.
- req_ready is 0 for all requesters in EXEC and RESP.
- Requesters hold valid and data stable until ready. valid must not depend on ready.
- Legal ops: AND=0000, OR=0001, ADD=0010, SUB=0110, PASSB=0111.
- Any other code takes the same path and latency but forces rsp_err=1, rsp_result=0, rsp_zero=0.
- Arithmetic is modulo 2^WIDTH; overflow is not flagged.
- Simultaneous requests: exactly one grant per accept. The last winner has lowest priority next time. Continuous contention alternates 0,1,0,1.
- ops_done wraps from all-ones to 0.

Decomposition:
- alu_pkg holds:
  - alu_op_t enum (the five legal codes);
  - arb_state_t {IDLE, EXEC, RESP};
  - function is_legal_op(logic [3:0]).
- Sub-module rr_arbiter(N) takes req, pointer and enable, and returns a one-hot grant plus grant index. It is purely combinational.
- The existing alu module is instantiated once.

Test Plan:
- req0 only: a=1, b=1, op=0010, accept at edge T -> rsp_valid[0]=1 after T+1, result=2, zero=0, err=0, ops_done=1 after the response handshake.
- req1: a=b=64'hFFFF_FFFF_FFFF_FFFF, op=0110 -> result=0, zero=1, rsp_valid=2'b10.
- Both valid from reset:
  - req0 ADD 5+3, req1 OR 0xF0|0x0F.
  - Grant order 0,1,0,1 -> results 8, 0xFF alternating.
  - rsp_valid one-hot matches the grant.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, result and zero held, req_ready=0. Raise ready -> IDLE next edge, ops_done+1.
- Illegal op 4'b1111 with a=7, b=9 -> err=1, result=0, zero=0, same 2-cycle latency.
- Edge cases:
  - Drop reset to 0 during EXEC -> all outputs 0 at once; after release, no stale response and requester 0 wins first.
  - ADD 64'h7FFF_FFFF_FFFF_FFFF + 1 -> 64'h8000_0000_0000_0000, zero=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the round-robin ALU arbiter slice.
// Holds the legal ALUControl encodings, the FSM states and the op legality check.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 64-bit ALU with a zero flag; unknown control codes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       control_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    always_comb begin
        result_o = '0;
        case (control_i)
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_ADD:   result_o = a_i + b_i;
            OP_SUB:   result_o = a_i - b_i;
            OP_PASSB: result_o = b_i;
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: searches from ptr_i+1 with wrap-around
// and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (en_i && !found_o && req_i[cand]) begin
                found_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N requesters: round-robin accept, one execute cycle,
// then a held response to the granted requester until it is taken.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N     = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0]              req_valid,
    output logic [N-1:0]              req_ready,
    input  logic [N-1:0][WIDTH-1:0]   req_a,
    input  logic [N-1:0][WIDTH-1:0]   req_b,
    input  logic [N-1:0][3:0]         req_op,
    output logic [N-1:0]              rsp_valid,
    input  logic [N-1:0]              rsp_ready,
    output logic [WIDTH-1:0]          rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [CNT_W-1:0]          ops_done
);

    localparam int IW = $clog2(N);

    arb_state_t       state_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    gnt_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic [3:0]       opCode_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             err_q;
    logic [N-1:0]     rspValid_q;
    logic             busy_q;
    logic [CNT_W-1:0] opsDone_q;
    logic [CNT_W-1:0] opsDone_d;

    logic [N-1:0]     arbGrant;
    logic [IW-1:0]    arbIdx;
    logic             arbFound;
    logic             arbEn;
    logic [WIDTH-1:0] aluResult;
    logic             aluZero;

    // Gating with reset keeps req_ready low while reset is held, even with valids up.
    assign arbEn = (state_q == IDLE) && reset;

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (arbEn),
        .grant_o (arbGrant),
        .idx_o   (arbIdx),
        .found_o (arbFound)
    );

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i       (opA_q),
        .b_i       (opB_q),
        .control_i (opCode_q),
        .result_o  (aluResult),
        .zero_o    (aluZero)
    );

    assign opsDone_d = opsDone_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(N - 1);
            gnt_q      <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            opCode_q   <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            rspValid_q <= '0;
            busy_q     <= 1'b0;
            opsDone_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arbFound) begin
                        opA_q    <= req_a[arbIdx];
                        opB_q    <= req_b[arbIdx];
                        opCode_q <= req_op[arbIdx];
                        gnt_q    <= arbIdx;
                        ptr_q    <= arbIdx;
                        busy_q   <= 1'b1;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal codes still take this cycle so latency is identical.
                    if (is_legal_op(opCode_q)) begin
                        result_q <= aluResult;
                        zero_q   <= aluZero;
                        err_q    <= 1'b0;
                    end else begin
                        result_q <= '0;
                        zero_q   <= 1'b0;
                        err_q    <= 1'b1;
                    end
                    rspValid_q <= N'(1) << gnt_q;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_q]) begin
                        opsDone_q  <= opsDone_d;
                        rspValid_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = arbGrant;
    assign rsp_valid  = rspValid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign busy       = busy_q;
    assign ops_done   = opsDone_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a transaction-level
// model of round-robin grant order and ALU arithmetic.
module tb_alu_arbiter;

    localparam int N     = 2;
    localparam int WIDTH = 64;
    localparam int CNT_W = 32;

    logic                    clk;
    logic                    reset;
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready;
    logic [N-1:0][WIDTH-1:0] req_a;
    logic [N-1:0][WIDTH-1:0] req_b;
    logic [N-1:0][3:0]       req_op;
    logic [N-1:0]            rsp_valid;
    logic [N-1:0]            rsp_ready;
    logic [WIDTH-1:0]        rsp_result;
    logic                    rsp_zero;
    logic                    rsp_err;
    logic                    busy;
    logic [CNT_W-1:0]        ops_done;

    int compared;
    int mismatched;

    // Model state: pending request per requester, last winner, completed count.
    logic             pend[N];
    logic [WIDTH-1:0] pa[N];
    logic [WIDTH-1:0] pb[N];
    logic [3:0]       po[N];
    int               lastWinner;
    int               modelOps;

    alu_arbiter #(
        .N     (N),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] oneHot(input int i);
        logic [63:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic void refAlu(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                                   output logic [63:0] r, output logic z, output logic e);
        e = 1'b0;
        case (int'(op))
            0:       r = a & b;
            1:       r = a | b;
            2:       r = a + b;
            6:       r = a - b;
            7:       r = b;
            default: begin r = '0; e = 1'b1; end
        endcase
        z = !e && (r == 64'd0);
    endfunction

    task automatic driveInputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_a[i]     = pa[i];
            req_b[i]     = pb[i];
            req_op[i]    = po[i];
        end
    endtask

    task automatic setPend(input int i, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        po[i]   = op;
    endtask

    // Runs one full transaction from a negedge; the model picks the winner.
    task automatic applyStimulus(input int holdCycles, input bit extraReady);
        int w;
        int idx;
        logic [63:0] expR;
        logic        expZ;
        logic        expE;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            idx = (lastWinner + k) % N;
            if (pend[idx] && w < 0) w = idx;
        end
        if (w < 0) return;
        driveInputs();
        #1;
        checkOutput("req_ready_grant", 64'(req_ready), oneHot(w));
        checkOutput("busy_idle", 64'(busy), 64'd0);
        refAlu(pa[w], pb[w], po[w], expR, expZ, expE);
        @(posedge clk);
        @(negedge clk);
        lastWinner = w;
        pend[w]    = 1'b0;
        checkOutput("req_ready_exec", 64'(req_ready), 64'd0);
        checkOutput("rsp_valid_exec", 64'(rsp_valid), 64'd0);
        checkOutput("busy_exec", 64'(busy), 64'd1);
        driveInputs();
        @(posedge clk);
        @(negedge clk);
        checkOutput("rsp_valid", 64'(rsp_valid), oneHot(w));
        checkOutput("rsp_result", rsp_result, expR);
        checkOutput("rsp_zero", 64'(rsp_zero), 64'(expZ));
        checkOutput("rsp_err", 64'(rsp_err), 64'(expE));
        checkOutput("req_ready_resp", 64'(req_ready), 64'd0);
        for (int c = 0; c < holdCycles; c++) begin
            rsp_ready = N'($urandom) & ~N'(oneHot(w));
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_rsp_valid", 64'(rsp_valid), oneHot(w));
            checkOutput("hold_result", rsp_result, expR);
            checkOutput("hold_zero", 64'(rsp_zero), 64'(expZ));
            checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = N'(oneHot(w));
        if (extraReady) rsp_ready = '1;
        @(posedge clk);
        modelOps++;
        @(negedge clk);
        checkOutput("ops_done", 64'(ops_done), 64'(modelOps));
        checkOutput("rsp_valid_done", 64'(rsp_valid), 64'd0);
        checkOutput("busy_done", 64'(busy), 64'd0);
        rsp_ready = '0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        lastWinner = N - 1;
        modelOps   = 0;
        for (int i = 0; i < N; i++) setPend(i, '0, '0, '0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        reset     = 1'b0;
        rsp_ready = '0;
        driveInputs();
        repeat (2) @(negedge clk);
        checkOutput("reset_ops_done", 64'(ops_done), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_result", rsp_result, 64'd0);
        checkOutput("reset_err", 64'(rsp_err), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        setPend(0, 64'd1, 64'd1, 4'b0010);
        applyStimulus(0, 1'b0);

        setPend(1, '1, '1, 4'b0110);
        applyStimulus(0, 1'b0);

        // Continuous contention: both stay valid and winners alternate.
        for (int r = 0; r < 4; r++) begin
            if (!pend[0]) setPend(0, 64'd5, 64'd3, 4'b0010);
            if (!pend[1]) setPend(1, 64'hF0, 64'h0F, 4'b0001);
            applyStimulus(0, 1'b1);
            checkOutput("alternate_winner", 64'(lastWinner), 64'(r % 2));
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;

        setPend(0, 64'hDEAD_BEEF_0000_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 4'b0000);
        applyStimulus(5, 1'b0);

        setPend(1, 64'd7, 64'd9, 4'b1111);
        applyStimulus(0, 1'b0);

        setPend(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
        applyStimulus(0, 1'b0);

        // Reset asserted while the ALU stage holds an op.
        setPend(0, 64'd11, 64'd22, 4'b0010);
        setPend(1, 64'd33, 64'd44, 4'b0010);
        driveInputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_mid_ops_done", 64'(ops_done), 64'd0);
        checkOutput("rst_mid_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_mid_result", rsp_result, 64'd0);
        modelOps   = 0;
        lastWinner = N - 1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        driveInputs();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            checkOutput("post_rst_busy", 64'(busy), 64'd0);
        end
        setPend(0, 64'd100, 64'd1, 4'b0110);
        setPend(1, 64'd200, 64'd2, 4'b0110);
        applyStimulus(0, 1'b0);
        checkOutput("post_rst_first_winner", 64'(lastWinner), 64'd0);

        // Random traffic with requesters holding until accepted.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    logic [63:0] a;
                    logic [63:0] b;
                    logic [3:0]  op;
                    int          sel;
                    a   = {$urandom, $urandom};
                    b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
                    sel = $urandom_range(0, 5);
                    case (sel)
                        0:       op = 4'b0000;
                        1:       op = 4'b0001;
                        2:       op = 4'b0010;
                        3:       op = 4'b0110;
                        4:       op = 4'b0111;
                        default: op = 4'($urandom_range(0, 15));
                    endcase
                    setPend(i, a, b, op);
                end
            end
            if (!pend[0] && !pend[1]) setPend($urandom_range(0, N - 1), {$urandom, $urandom}, 64'd0, 4'b0111);
            applyStimulus($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
